ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the 4-stage pipeline control chain (ID -> EX -> MEM -> WB).
- Carries the decoded instruction word, ALU select and write-back enable through the stages, each stage with a valid bit.
- Adds global stall, branch flush and RAW-hazard interlock with bubble insertion.
- Sits between the instruction decoder/cache and the datapath (ALU select to EX, register-file write port from WB).

Parameters:
- IR_W, 16, instruction word width.
- ALU_W, 3, ALU select width.
- AW, 4, register address width.
- RD_LSB, 8, LSB of the rd field in the instruction word.
- RS1_LSB, 4, LSB of the rs1 field.
- RS2_LSB, 0, LSB of the rs2 field.
- HAZ_EN, 1, 1 enables RAW interlock; 0 makes o_hazard constant 0.
- ZERO_REG, 1, 1 means register 0 is hardwired; rd==0 never creates a hazard or a write.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  decoder presents an instruction this cycle.
- i_alu_sel  in  ALU_W  ALU select for the presented instruction.
- i_wb_en  in  1  instruction writes rd.
- i_ir_cache  in  IR_W  instruction word.
- i_stall  in  1  external freeze (memory wait).
- i_flush  in  1  branch resolved taken; kill younger instructions.
- o_ready  out  1  ID accepts this cycle (= !i_stall && !hazard).
- o_hazard  out  1  RAW interlock active this cycle.
- o_alu_sel  out  ALU_W  EX-stage ALU select (0 when EX invalid).
- o_ex_valid  out  1  EX stage holds a real instruction.
- o_ir_mem  out  IR_W  instruction word in MEM stage.
- o_addr_rd_r  out  AW  write-back register address (registered).
- o_registers_rd_en  out  1  register-file write enable (registered).

Behaviour:
- Stages ID, EX, MEM, WB are each registers {valid, alu_sel, wb_en, ir}.
- Reset (rst==0 at a rising edge): all valid=0, all fields 0. o_alu_sel=0, o_ex_valid=0, o_ir_mem=0, o_addr_rd_r=0, o_registers_rd_en=0, o_hazard=0. o_ready=0 during reset, 1 after if no stall.
- Latency: instruction accepted at edge N (i_valid && o_ready) is in ID after N, EX after N+1, MEM after N+2, WB after N+3. o_registers_rd_en=1 and o_addr_rd_r=rd during cycle N+3..N+4.
- Hazard (HAZ_EN=1): ID valid and rs1 or rs2 equals rd of any valid, wb_en stage in EX/MEM/WB. With ZERO_REG=1, rd==0 is excluded. Combinational from the stage registers.
- Hazard, no stall: ID holds, EX loads a bubble (valid=0, alu_sel=0, wb_en=0), MEM and WB advance.
- i_stall=1: every stage holds its contents. The WB write enable is deasserted during a stall, so a held WB entry writes exactly once. Hazard is still reported but has no effect.
- i_flush=1: at the next edge ID.valid and EX.valid are cleared, and the input is not captured. MEM and WB advance normally, or hold if i_stall.
- Priority: flush beats hazard. Flush clears its target stages even during a stall.
- i_valid=0 with o_ready=1: ID loads a bubble.
- Write-back: o_registers_rd_en = WB.valid && WB.wb_en && !(ZERO_REG && rd==0) && !stall. The enable is registered from the MEM->WB transfer.
- Invalid stages never cause a hazard or a write. Their ir field is don't-care but is driven to 0 on bubble insertion.
- Reset mid-operation overrides stall and flush; all in-flight instructions are dropped.

Decomposition:
- Package ctrl_pkg holds:
  - stage struct typedef (valid, alu_sel, wb_en, ir);
  - field-extract functions rd_of(), rs1_of(), rs2_of();
  - BUBBLE constant.
- Sub-module ctrl_stage_reg: one parametrised stage register with load/hold/bubble controls and synchronous active-low reset. Instantiate it 4 times.
- Hazard compare and write-back enable stay in ctrl_pipe.

Test Plan:
- Straight-line: accept ir=0x0312 (rd=3), wb_en=1 at edge 1, no stall -> o_alu_sel valid during cycle 2; o_registers_rd_en=1 with o_addr_rd_r=3 for exactly one cycle after edge 4.
- RAW: ir=0x0500 (rd=5), then ir=0x0150 (rs1=5) back-to-back -> o_hazard=1 and o_ready=0 for 3 cycles. The dependent instruction reaches EX only after the producer leaves WB; 3 bubbles appear with o_ex_valid=0.
- ZERO_REG: producer rd=0, consumer rs1=0 -> o_hazard stays 0 and o_registers_rd_en never asserts for rd=0.
- Stall: assert i_stall for 2 cycles while the WB entry is valid -> all outputs frozen and exactly one write pulse after release.
- Flush + stall same cycle, with EX and ID valid -> both invalid after the edge; MEM/WB contents unchanged; no write from the flushed instructions.
- Reset mid-stream: rst=0 for one edge with 4 valid stages -> all outputs 0 next cycle and no write pulse afterwards.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and field helpers for the ID/EX/MEM/WB control chain.
// Stage records are sized for the widest supported configuration; narrower instances zero-fill.
package ctrl_pkg;

  localparam int IR_MAX  = 32;
  localparam int ALU_MAX = 8;
  localparam int AW_MAX  = 8;

  typedef struct packed {
    logic               valid;
    logic [ALU_MAX-1:0] alu_sel;
    logic               wb_en;
    logic [IR_MAX-1:0]  ir;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic logic [AW_MAX-1:0] fld(input logic [IR_MAX-1:0] ir, input int lsb, input int aw);
    logic [IR_MAX-1:0] mask;
    mask = ~({IR_MAX{1'b1}} << aw);
    return AW_MAX'((ir >> lsb) & mask);
  endfunction

  // Defaults describe the base 16-bit encoding; callers pass their own layout.
  function automatic logic [AW_MAX-1:0] rd_of(input logic [IR_MAX-1:0] ir, input int aw = 4, input int lsb = 8);
    return fld(ir, lsb, aw);
  endfunction

  function automatic logic [AW_MAX-1:0] rs1_of(input logic [IR_MAX-1:0] ir, input int aw = 4, input int lsb = 4);
    return fld(ir, lsb, aw);
  endfunction

  function automatic logic [AW_MAX-1:0] rs2_of(input logic [IR_MAX-1:0] ir, input int aw = 4, input int lsb = 0);
    return fld(ir, lsb, aw);
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: bubble beats load, otherwise hold.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter type T       = stage_t,
  parameter T    RST_VAL = '0
)(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bubble,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (!rst || bubble) q <= RST_VAL;
    else if (load)      q <= d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control chain with global stall, branch flush and RAW interlock.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int IR_W     = 16,
  parameter int ALU_W    = 3,
  parameter int AW       = 4,
  parameter int RD_LSB   = 8,
  parameter int RS1_LSB  = 4,
  parameter int RS2_LSB  = 0,
  parameter bit HAZ_EN   = 1'b1,
  parameter bit ZERO_REG = 1'b1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [ALU_W-1:0] i_alu_sel,
  input  logic             i_wb_en,
  input  logic [IR_W-1:0]  i_ir_cache,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_hazard,
  output logic [ALU_W-1:0] o_alu_sel,
  output logic             o_ex_valid,
  output logic [IR_W-1:0]  o_ir_mem,
  output logic [AW-1:0]    o_addr_rd_r,
  output logic             o_registers_rd_en
);

  localparam int NSTG = 4;
  localparam int ID = 0, EX = 1, MEM = 2, WB = 3;

  stage_t [NSTG-1:0] stg_d, stg_q;
  logic   [NSTG-1:0] ld, bub;
  logic   [NSTG-1:1] wr_live, hit;
  logic [AW_MAX-1:0] rs1, rs2, rd_s;
  logic              hazard, we_r;
  logic              unused_wb;

  // An older stage blocks ID when it will write a register ID reads.
  always_comb begin
    rs1     = rs1_of(stg_q[ID].ir, AW, RS1_LSB);
    rs2     = rs2_of(stg_q[ID].ir, AW, RS2_LSB);
    rd_s    = '0;
    wr_live = '0;
    hit     = '0;
    for (int s = EX; s <= WB; s++) begin
      rd_s       = rd_of(stg_q[s].ir, AW, RD_LSB);
      wr_live[s] = stg_q[s].valid && stg_q[s].wb_en && !(ZERO_REG && rd_s == '0);
      hit[s]     = wr_live[s] && (rd_s == rs1 || rd_s == rs2);
    end
    hazard = HAZ_EN && rst && stg_q[ID].valid && (|hit);
  end

  assign o_ready = rst && !i_stall && !hazard;

  always_comb begin
    stg_d[ID]  = i_valid ? '{valid: 1'b1, alu_sel: ALU_MAX'(i_alu_sel), wb_en: i_wb_en,
                             ir: IR_MAX'(i_ir_cache)} : BUBBLE;
    stg_d[EX]  = stg_q[ID];
    stg_d[MEM] = stg_q[EX];
    stg_d[WB]  = stg_q[MEM];
    ld         = {NSTG{!i_stall}};
    ld[ID]     = o_ready;
    bub        = '0;
    bub[ID]    = i_flush;
    bub[EX]    = i_flush || (!i_stall && hazard);
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    ctrl_stage_reg #(.T(stage_t), .RST_VAL(BUBBLE)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (ld[s]),
      .bubble (bub[s]),
      .d      (stg_d[s]),
      .q      (stg_q[s])
    );
  end

  // Follows the MEM->WB transfer and holds with WB during a stall.
  always_ff @(posedge clk) begin
    if (!rst)          we_r <= 1'b0;
    else if (!i_stall) we_r <= wr_live[MEM];
  end

  assign o_hazard          = hazard;
  assign o_alu_sel         = stg_q[EX].valid ? ALU_W'(stg_q[EX].alu_sel) : '0;
  assign o_ex_valid        = stg_q[EX].valid;
  assign o_ir_mem          = IR_W'(stg_q[MEM].ir);
  assign o_addr_rd_r       = AW'(rd_of(stg_q[WB].ir, AW, RD_LSB));
  assign o_registers_rd_en = we_r && !i_stall;

  // WB's ALU select has no consumer.
  assign unused_wb = ^stg_q[WB].alu_sel;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Random and directed stimulus against an instruction-slot model of the control chain.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_wb_en, i_stall, i_flush;
  logic [2:0]  i_alu_sel;
  logic [15:0] i_ir_cache;
  logic        o_ready, o_hazard, o_ex_valid, o_registers_rd_en;
  logic [2:0]  o_alu_sel;
  logic [15:0] o_ir_mem;
  logic [3:0]  o_addr_rd_r;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk               (clk),
    .rst               (rst),
    .i_valid           (i_valid),
    .i_alu_sel         (i_alu_sel),
    .i_wb_en           (i_wb_en),
    .i_ir_cache        (i_ir_cache),
    .i_stall           (i_stall),
    .i_flush           (i_flush),
    .o_ready           (o_ready),
    .o_hazard          (o_hazard),
    .o_alu_sel         (o_alu_sel),
    .o_ex_valid        (o_ex_valid),
    .o_ir_mem          (o_ir_mem),
    .o_addr_rd_r       (o_addr_rd_r),
    .o_registers_rd_en (o_registers_rd_en)
  );

  typedef struct { bit v; int alu; bit wb; int ir; } ins_t;

  ins_t pl[4];   // 0=ID .. 3=WB, what each slot holds now
  int   n_vec, n_bad, cyc_n;
  int   wr_cnt, wr_mask, haz_cnt;

  function automatic int fld(int ir, int lsb);
    return (ir >> lsb) & 15;
  endfunction

  function automatic ins_t empty_slot();
    ins_t e;
    e = '{v: 1'b0, alu: 0, wb: 1'b0, ir: 0};
    return e;
  endfunction

  // ID waits while any older slot will still write a register it reads (r0 never counts).
  function automatic bit m_haz();
    int a, b, r;
    if (!pl[0].v) return 1'b0;
    a = fld(pl[0].ir, 4);
    b = fld(pl[0].ir, 0);
    for (int s = 1; s < 4; s++) begin
      r = fld(pl[s].ir, 8);
      if (pl[s].v && pl[s].wb && r != 0 && (r == a || r == b)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input int alu, input bit wb, input int ir,
                      input bit st, input bit fl);
    bit   haz;
    ins_t nx[4];
    @(negedge clk);
    rst = r; i_valid = v; i_alu_sel = 3'(alu); i_wb_en = wb; i_ir_cache = 16'(ir);
    i_stall = st; i_flush = fl;
    #1;
    haz = m_haz();
    chk("ready", o_ready, r && !st && !haz);
    if (r) chk("hazard", o_hazard, haz);
    chk("ex_valid", o_ex_valid, pl[1].v);
    chk("alu_sel", o_alu_sel, pl[1].v ? pl[1].alu : 0);
    chk("ir_mem", o_ir_mem, pl[2].v ? pl[2].ir : 0);
    chk("addr_rd", o_addr_rd_r, pl[3].v ? fld(pl[3].ir, 8) : 0);
    chk("rd_en", o_registers_rd_en, pl[3].v && pl[3].wb && fld(pl[3].ir, 8) != 0 && !st);
    if (o_registers_rd_en === 1'b1) begin
      wr_cnt++;
      wr_mask |= 1 << o_addr_rd_r;
    end
    if (o_hazard === 1'b1) haz_cnt++;
    // slot contents after the coming rising edge
    nx = pl;
    if (!r) begin
      for (int s = 0; s < 4; s++) nx[s] = empty_slot();
    end else begin
      if (!st) begin
        nx[3] = pl[2];
        nx[2] = pl[1];
        if (haz) nx[1] = empty_slot();
        else begin
          nx[1] = pl[0];
          nx[0] = v ? '{v: 1'b1, alu: alu, wb: wb, ir: ir} : empty_slot();
        end
      end
      if (fl) begin
        nx[0] = empty_slot();
        nx[1] = empty_slot();
      end
    end
    pl = nx;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic issue(input int alu, input bit wb, input int ir);
    step(1'b1, 1'b1, alu, wb, ir, 1'b0, 1'b0);
  endtask

  task automatic clr_obs();
    wr_cnt = 0; wr_mask = 0; haz_cnt = 0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc_n = 0;
    rst = 1'b0; i_valid = 1'b0; i_alu_sel = '0; i_wb_en = 1'b0; i_ir_cache = '0;
    i_stall = 1'b0; i_flush = 1'b0;
    for (int s = 0; s < 4; s++) pl[s] = empty_slot();
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // straight-line, rd=3
    clr_obs();
    issue(5, 1'b1, 'h0312);
    idle(6);
    chk("straight_wr_cnt", wr_cnt, 1);
    chk("straight_wr_addr", wr_mask, 1 << 3);

    // RAW on r5, consumer writes r1
    clr_obs();
    issue(1, 1'b1, 'h0500);
    issue(2, 1'b1, 'h0150);
    idle(8);
    chk("raw_haz_cycles", haz_cnt, 3);
    chk("raw_wr_set", wr_mask, (1 << 5) | (1 << 1));

    // r0 producer never interlocks nor writes
    clr_obs();
    issue(3, 1'b1, 'h0000);
    issue(4, 1'b0, 'h0100);
    idle(6);
    chk("zero_haz", haz_cnt, 0);
    chk("zero_wr", wr_cnt, 0);

    // 2-cycle stall with a live WB entry; offered instruction is not taken
    clr_obs();
    issue(3, 1'b1, 'h0712);
    idle(3);
    step(1'b1, 1'b1, 4, 1'b1, 'h0900, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4, 1'b1, 'h0900, 1'b1, 1'b0);
    idle(5);
    chk("stall_wr_cnt", wr_cnt, 1);
    chk("stall_wr_addr", wr_mask, 1 << 7);

    // flush together with stall: C and D die, A and B retire
    clr_obs();
    issue(1, 1'b1, 'h0200);
    issue(2, 1'b1, 'h0300);
    issue(3, 1'b1, 'h0400);
    issue(4, 1'b1, 'h0600);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
    idle(6);
    chk("flush_wr_cnt", wr_cnt, 2);
    chk("flush_wr_set", wr_mask, (1 << 2) | (1 << 3));

    // reset with four live stages
    issue(1, 1'b1, 'h0200);
    issue(2, 1'b1, 'h0300);
    issue(3, 1'b1, 'h0400);
    issue(4, 1'b1, 'h0600);
    step(1'b0, 1'b1, 5, 1'b1, 'h0800, 1'b1, 1'b1);
    clr_obs();
    idle(6);
    chk("reset_wr_cnt", wr_cnt, 0);

    // random traffic with a narrow register range to provoke interlocks
    for (int k = 0; k < 800; k++) begin
      int ir;
      ir = int'($urandom_range(0, 15) << 12) | int'($urandom_range(0, 3) << 8) |
           int'($urandom_range(0, 3) << 4) | int'($urandom_range(0, 3));
      step($urandom_range(0, 99) >= 2, $urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, ir, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
